// File: rtl/sht40_pkg.sv
// -----------------------------------------------------------------------------
// sht40_pkg
// Shared constants, FSM state encoding and a small helper for the SHT40
// receive-frame checker.
//   SHT40_CRC_POLY        CRC-8 polynomial x^8+x^5+x^4+1
//   SHT40_CRC_INIT        CRC register value at the start of each word
//   SHT40_BYTES_PER_WORD  2 data bytes + 1 CRC byte
//   state_t               IDLE / SHIFT / CHECK / DONE
//   byte_pos()            role of a byte within its word (0,1 data; 2 CRC)
// -----------------------------------------------------------------------------
package sht40_pkg;

    localparam logic [7:0] SHT40_CRC_POLY       = 8'h31;
    localparam logic [7:0] SHT40_CRC_INIT       = 8'hFF;
    localparam int         SHT40_BYTES_PER_WORD = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // byte_index mod 3 for the only legal index range 0..5, without a divider.
    function automatic logic [1:0] byte_pos(input logic [2:0] idx);
        logic [1:0] pos;
        pos = 2'd2;
        case (idx)
            3'd0, 3'd3: pos = 2'd0;
            3'd1, 3'd4: pos = 2'd1;
            default:    pos = 2'd2;
        endcase
        return pos;
    endfunction

endpackage

// File: rtl/sht40_rx_frame_checker_if.sv
// -----------------------------------------------------------------------------
// sht40_rx_frame_checker_if
// Byte stream from the I2C master into the frame checker.
//   frame_start    1-cycle pulse that begins a new frame
//   rx_byte_valid  1-cycle pulse: rx_byte holds a completed received byte
//   rx_byte        received byte, bit 7 was first on the wire
//   busy           checker is shifting a data byte through its CRC
// master: the byte source (I2C master).  slave: the frame checker.
// -----------------------------------------------------------------------------
interface sht40_rx_frame_checker_if;

    logic       frame_start;
    logic       rx_byte_valid;
    logic [7:0] rx_byte;
    logic       busy;

    modport master (
        output frame_start,
        output rx_byte_valid,
        output rx_byte,
        input  busy
    );

    modport slave (
        input  frame_start,
        input  rx_byte_valid,
        input  rx_byte,
        output busy
    );

endinterface

// File: rtl/sht40_crc8_serial.sv
// -----------------------------------------------------------------------------
// sht40_crc8_serial
// Bit-serial CRC-8 register, one message bit per enabled clock, MSB first.
//   clk, rst   clock and asynchronous active-high reset (crc <= INIT)
//   init       reload crc with INIT (wins over shift_en)
//   shift_en   absorb data_bit this cycle
//   data_bit   next message bit
//   crc        current CRC register
// -----------------------------------------------------------------------------
module sht40_crc8_serial
    import sht40_pkg::*;
#(
    parameter logic [7:0] POLY = SHT40_CRC_POLY,
    parameter logic [7:0] INIT = SHT40_CRC_INIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init,
    input  logic       shift_en,
    input  logic       data_bit,
    output logic [7:0] crc
);

    logic feedback;

    assign feedback = crc[7] ^ data_bit;

    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values of its neighbours, whatever the order of
    // statements.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= INIT;
        end else if (init) begin
            crc <= INIT;
        end else if (shift_en) begin
            crc <= {crc[6:0], 1'b0} ^ (feedback ? POLY : 8'h00);
        end
    end

endmodule

// File: rtl/sht40_rx_frame_checker.sv
// -----------------------------------------------------------------------------
// sht40_rx_frame_checker
// Assembles the bytes of an SHT40 measurement read into 16-bit words, each
// protected by a CRC-8 byte, and reports the frame result.
//   clk, rst      system clock, asynchronous active-high reset
//   rx            byte stream from the I2C master (slave modport, drives busy)
//   byte_index    bytes accepted in the current frame, saturates at 3*NUM_WORDS
//   temp_raw      word 0, updated only when a whole frame checks good
//   hum_raw       word 1, likewise; 0 when NUM_WORDS = 1
//   frame_valid   1-cycle pulse: all words received with matching CRCs
//   crc_error     sticky: CRC mismatch or overrun in this frame
//   overrun       sticky: a byte arrived while the checker could not take it
// -----------------------------------------------------------------------------
module sht40_rx_frame_checker
    import sht40_pkg::*;
#(
    parameter int         NUM_WORDS = 2,
    parameter logic [7:0] CRC_POLY  = SHT40_CRC_POLY,
    parameter logic [7:0] CRC_INIT  = SHT40_CRC_INIT
) (
    input  logic                     clk,
    input  logic                     rst,
    sht40_rx_frame_checker_if.slave  rx,
    output logic [2:0]               byte_index,
    output logic [15:0]              temp_raw,
    output logic [15:0]              hum_raw,
    output logic                     frame_valid,
    output logic                     crc_error,
    output logic                     overrun
);

    localparam logic [2:0] LAST_INDEX = 3'(SHT40_BYTES_PER_WORD * NUM_WORDS);

    state_t      state;
    logic [7:0]  sh_reg;     // byte being shifted, or the CRC byte under check
    logic [2:0]  bit_cnt;
    logic [15:0] stage;      // word being assembled
    logic [15:0] hold0;      // word 0 after its CRC byte arrived
    logic [15:0] hold1;      // word 1 after its CRC byte arrived
    logic        busy_q;

    logic        crc_init;
    logic        crc_shift;
    logic [7:0]  crc;

    // The CRC is reloaded on the CHECK cycle so the next word starts clean,
    // and on frame_start so an aborted shift leaves nothing behind.
    assign crc_init  = rx.frame_start || (state == ST_CHECK);
    assign crc_shift = (state == ST_SHIFT) && !rx.frame_start;
    assign rx.busy   = busy_q;

    sht40_crc8_serial #(
        .POLY (CRC_POLY),
        .INIT (CRC_INIT)
    ) u_crc (
        .clk      (clk),
        .rst      (rst),
        .init     (crc_init),
        .shift_en (crc_shift),
        .data_bit (sh_reg[7]),
        .crc      (crc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            sh_reg      <= 8'h00;
            bit_cnt     <= 3'd0;
            stage       <= 16'h0000;
            hold0       <= 16'h0000;
            hold1       <= 16'h0000;
            busy_q      <= 1'b0;
            byte_index  <= 3'd0;
            temp_raw    <= 16'h0000;
            hum_raw     <= 16'h0000;
            frame_valid <= 1'b0;
            crc_error   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            // NOTE: the default here makes frame_valid a single-cycle pulse;
            // only the DONE branch below raises it.
            frame_valid <= 1'b0;

            if (rx.frame_start) begin
                // A byte arriving together with frame_start is dropped silently.
                state      <= ST_IDLE;
                busy_q     <= 1'b0;
                bit_cnt    <= 3'd0;
                byte_index <= 3'd0;
                stage      <= 16'h0000;
                hold0      <= 16'h0000;
                hold1      <= 16'h0000;
                crc_error  <= 1'b0;
                overrun    <= 1'b0;
            end else begin
                if (rx.rx_byte_valid && (state != ST_IDLE)) begin
                    overrun   <= 1'b1;
                    crc_error <= 1'b1;
                end

                case (state)
                    ST_IDLE: begin
                        // Once saturated, extra bytes are ignored until frame_start.
                        if (rx.rx_byte_valid && (byte_index != LAST_INDEX)) begin
                            sh_reg     <= rx.rx_byte;
                            byte_index <= byte_index + 3'd1;
                            case (byte_pos(byte_index))
                                2'd0: begin
                                    stage[15:8] <= rx.rx_byte;
                                    bit_cnt     <= 3'd7;
                                    busy_q      <= 1'b1;
                                    state       <= ST_SHIFT;
                                end
                                2'd1: begin
                                    stage[7:0] <= rx.rx_byte;
                                    bit_cnt    <= 3'd7;
                                    busy_q     <= 1'b1;
                                    state      <= ST_SHIFT;
                                end
                                default: begin
                                    state <= ST_CHECK;
                                end
                            endcase
                        end
                    end

                    ST_SHIFT: begin
                        sh_reg <= {sh_reg[6:0], 1'b0};
                        if (bit_cnt == 3'd0) begin
                            busy_q <= 1'b0;
                            state  <= ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt - 3'd1;
                        end
                    end

                    ST_CHECK: begin
                        if (sh_reg != crc) begin
                            crc_error <= 1'b1;
                        end
                        if (byte_index == 3'd3) begin
                            hold0 <= stage;
                        end else begin
                            hold1 <= stage;
                        end
                        state <= (byte_index == LAST_INDEX) ? ST_DONE : ST_IDLE;
                    end

                    ST_DONE: begin
                        // crc_error here already includes this frame's last CHECK.
                        if (!crc_error) begin
                            temp_raw    <= hold0;
                            hum_raw     <= (NUM_WORDS == 2) ? hold1 : 16'h0000;
                            frame_valid <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sht40_rx_frame_checker.sv
// -----------------------------------------------------------------------------
// tb_sht40_rx_frame_checker
// Drives one byte stream into two checkers (NUM_WORDS = 2 and NUM_WORDS = 1)
// and compares both against a timeline model of the frame rules every cycle,
// plus directed scenarios with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_sht40_rx_frame_checker;

    logic       clk;
    logic       rst;
    logic       fs;
    logic       rv;
    logic [7:0] rb;

    logic [2:0]  bi   [2];
    logic [15:0] temp [2];
    logic [15:0] hum  [2];
    logic        fv   [2];
    logic        cerr [2];
    logic        ovr  [2];
    logic        bsy  [2];

    sht40_rx_frame_checker_if bus0 ();
    sht40_rx_frame_checker_if bus1 ();

    assign bus0.frame_start   = fs;
    assign bus0.rx_byte_valid = rv;
    assign bus0.rx_byte       = rb;
    assign bus1.frame_start   = fs;
    assign bus1.rx_byte_valid = rv;
    assign bus1.rx_byte       = rb;
    assign bsy[0] = bus0.busy;
    assign bsy[1] = bus1.busy;

    sht40_rx_frame_checker #(.NUM_WORDS(2)) dut0 (
        .clk         (clk),
        .rst         (rst),
        .rx          (bus0),
        .byte_index  (bi[0]),
        .temp_raw    (temp[0]),
        .hum_raw     (hum[0]),
        .frame_valid (fv[0]),
        .crc_error   (cerr[0]),
        .overrun     (ovr[0])
    );

    sht40_rx_frame_checker #(.NUM_WORDS(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .rx          (bus1),
        .byte_index  (bi[1]),
        .temp_raw    (temp[1]),
        .hum_raw     (hum[1]),
        .frame_valid (fv[1]),
        .crc_error   (cerr[1]),
        .overrun     (ovr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Byte-wise CRC-8 over one word: XOR the byte in, then 8 polynomial steps.
    function automatic logic [7:0] crc8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] c;
        c = 8'hFF;
        for (int k = 0; k < 2; k++) begin
            c = c ^ ((k == 0) ? a : b);
            for (int j = 0; j < 8; j++)
                c = c[7] ? ({c[6:0], 1'b0} ^ 8'h31) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    // ---------------- timeline model ----------------
    // Edge numbers: a byte accepted at edge t blocks further bytes until
    // edge t+9 (data) or t+2 / t+3 (CRC, last CRC). Its CRC verdict lands
    // at edge t+1; the frame result at edge t+2.
    int          cyc = 0;
    int          m_max      [2] = '{6, 3};
    int          m_idx      [2];
    bit          m_err      [2];
    bit          m_ovr      [2];
    bit          m_fv       [2];
    logic [15:0] m_temp     [2];
    logic [15:0] m_hum      [2];
    int          m_lock     [2];
    int          m_busy_end [2];
    int          m_check_at [2];
    int          m_done_at  [2];
    bit          m_bad      [2];
    logic [7:0]  m_bytes    [2][6];
    int          fv_cnt     [2] = '{0, 0};

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_idx[d] = 0; m_err[d] = 0; m_ovr[d] = 0; m_fv[d] = 0;
            m_temp[d] = 16'h0; m_hum[d] = 16'h0;
            m_lock[d] = 0; m_busy_end[d] = 0; m_check_at[d] = -1; m_done_at[d] = -1;
            m_bad[d] = 0;
        end
    endtask

    task automatic model_step(input int d);
        m_fv[d] = 0;
        if (fs) begin
            m_idx[d] = 0; m_err[d] = 0; m_ovr[d] = 0;
            m_lock[d] = 0; m_busy_end[d] = 0; m_check_at[d] = -1; m_done_at[d] = -1;
        end else begin
            if (cyc == m_check_at[d] && m_bad[d]) m_err[d] = 1;
            if (cyc == m_done_at[d] && !m_err[d]) begin
                m_fv[d]   = 1;
                m_temp[d] = {m_bytes[d][0], m_bytes[d][1]};
                m_hum[d]  = (m_max[d] == 6) ? {m_bytes[d][3], m_bytes[d][4]} : 16'h0;
            end
            if (rv) begin
                if (cyc < m_lock[d]) begin
                    m_ovr[d] = 1;
                    m_err[d] = 1;
                end else if (m_idx[d] < m_max[d]) begin
                    m_bytes[d][m_idx[d]] = rb;
                    if (m_idx[d] % 3 != 2) begin
                        m_busy_end[d] = cyc + 8;
                        m_lock[d]     = cyc + 9;
                    end else begin
                        m_bad[d]      = (rb != crc8(m_bytes[d][m_idx[d]-2], m_bytes[d][m_idx[d]-1]));
                        m_check_at[d] = cyc + 1;
                        if (m_idx[d] + 1 == m_max[d]) begin
                            m_done_at[d] = cyc + 2;
                            m_lock[d]    = cyc + 3;
                        end else begin
                            m_lock[d] = cyc + 2;
                        end
                    end
                    m_idx[d]++;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            model_step(0);
            model_step(1);
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d byte_index", d), 32'(bi[d]), 32'(m_idx[d]));
            check($sformatf("dut%0d busy", d), 32'(bsy[d]), 32'(cyc < m_busy_end[d] && !rst));
            check($sformatf("dut%0d frame_valid", d), 32'(fv[d]), 32'(m_fv[d]));
            check($sformatf("dut%0d crc_error", d), 32'(cerr[d]), 32'(m_err[d]));
            check($sformatf("dut%0d overrun", d), 32'(ovr[d]), 32'(m_ovr[d]));
            check($sformatf("dut%0d temp_raw", d), 32'(temp[d]), 32'(m_temp[d]));
            check($sformatf("dut%0d hum_raw", d), 32'(hum[d]), 32'(m_hum[d]));
            if (fv[d] === 1'b1) fv_cnt[d]++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic start();
        fs = 1'b1;
        tick();
        fs = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rb = b;
        rv = 1'b1;
        tick();
        rv = 1'b0;
    endtask

    task automatic good_frame();
        logic [7:0] seq [6];
        seq = '{8'hBE, 8'hEF, 8'h92, 8'hBE, 8'hEF, 8'h92};
        start();
        for (int i = 0; i < 6; i++) begin
            send_byte(seq[i]);
            idle(30);
        end
    endtask

    int fv0_before;
    int fv1_before;

    initial begin
        rst = 1'b1; fs = 1'b0; rv = 1'b0; rb = 8'h00;
        model_reset();

        // Model pins: published SHT40 CRC examples.
        check("model crc8 BEEF", 32'(crc8(8'hBE, 8'hEF)), 32'h92);
        check("model crc8 0000", 32'(crc8(8'h00, 8'h00)), 32'h81);

        idle(3);
        check("reset byte_index", 32'(bi[0]), 32'd0);
        check("reset crc_error", 32'(cerr[0]), 32'd0);
        check("reset temp_raw", 32'(temp[0]), 32'd0);
        rst = 1'b0;
        idle(2);

        // 1. Good frame.
        fv0_before = fv_cnt[0];
        good_frame();
        check("good temp_raw", 32'(temp[0]), 32'hBEEF);
        check("good hum_raw", 32'(hum[0]), 32'hBEEF);
        check("good crc_error", 32'(cerr[0]), 32'd0);
        check("good frame_valid count", 32'(fv_cnt[0] - fv0_before), 32'd1);
        check("nw1 temp_raw", 32'(temp[1]), 32'hBEEF);
        check("nw1 hum_raw", 32'(hum[1]), 32'h0);

        // 2. Bad temperature CRC, sticky.
        fv0_before = fv_cnt[0];
        start();
        send_byte(8'hBE); idle(30);
        send_byte(8'hEF); idle(30);
        send_byte(8'h93); idle(2);
        check("badcrc crc_error after check", 32'(cerr[0]), 32'd1);
        idle(28);
        send_byte(8'hBE); idle(30);
        send_byte(8'hEF); idle(30);
        send_byte(8'h92); idle(30);
        check("badcrc crc_error sticky", 32'(cerr[0]), 32'd1);
        check("badcrc no frame_valid", 32'(fv_cnt[0] - fv0_before), 32'd0);
        check("badcrc temp_raw kept", 32'(temp[0]), 32'hBEEF);

        // 3. Overrun.
        start();
        send_byte(8'hBE);
        idle(2);
        send_byte(8'hEF);
        check("overrun flag", 32'(ovr[0]), 32'd1);
        check("overrun crc_error", 32'(cerr[0]), 32'd1);
        check("overrun byte_index", 32'(bi[0]), 32'd1);
        idle(12);

        // 4. Abort 4 clocks into the shift of byte 2.
        start();
        send_byte(8'hBE); idle(20);
        send_byte(8'hEF); idle(3);
        start();
        check("abort byte_index", 32'(bi[0]), 32'd0);
        check("abort busy", 32'(bsy[0]), 32'd0);
        fv0_before = fv_cnt[0];
        good_frame();
        check("abort then good frame_valid", 32'(fv_cnt[0] - fv0_before), 32'd1);

        // frame_start together with a byte: byte dropped, no overrun.
        fs = 1'b1;
        send_byte(8'h55);
        fs = 1'b0;
        check("start+byte byte_index", 32'(bi[0]), 32'd0);
        check("start+byte overrun", 32'(ovr[0]), 32'd0);

        // 5. Reset mid-frame.
        start();
        for (int i = 0; i < 4; i++) begin
            send_byte((i % 3 == 0) ? 8'hBE : (i % 3 == 1) ? 8'hEF : 8'h92);
            idle(4);
        end
        rst = 1'b1;
        model_reset();
        #1;
        check("rst byte_index", 32'(bi[0]), 32'd0);
        check("rst busy", 32'(bsy[0]), 32'd0);
        check("rst temp_raw", 32'(temp[0]), 32'd0);
        idle(2);
        rst = 1'b0;
        idle(1);
        good_frame();
        check("post-rst temp_raw", 32'(temp[0]), 32'hBEEF);

        // 6. NUM_WORDS=1 latency: frame_valid two clocks after the 3rd byte.
        fv1_before = fv_cnt[1];
        start();
        send_byte(8'hBE); idle(30);
        send_byte(8'hEF); idle(30);
        send_byte(8'h92);
        check("nw1 fv at +0", 32'(fv[1]), 32'd0);
        tick();
        check("nw1 fv at +1", 32'(fv[1]), 32'd0);
        tick();
        check("nw1 fv at +2", 32'(fv[1]), 32'd1);
        idle(10);
        check("nw1 fv count", 32'(fv_cnt[1] - fv1_before), 32'd1);

        // Randomized frames: random data, occasional corrupt CRC, tight gaps
        // that overrun, aborts and frame_start colliding with a byte.
        for (int f = 0; f < 40; f++) begin
            logic [7:0] d0, d1, c;
            start();
            for (int w = 0; w < 2; w++) begin
                d0 = 8'($urandom);
                d1 = 8'($urandom);
                c  = crc8(d0, d1);
                if ($urandom_range(0, 3) == 0) c = c ^ 8'(1 << $urandom_range(0, 7));
                for (int b = 0; b < 3; b++) begin
                    int gap;
                    gap = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 8) : $urandom_range(9, 14);
                    if ($urandom_range(0, 23) == 0) begin
                        fs = 1'b1;
                        send_byte(8'($urandom));
                        fs = 1'b0;
                    end else begin
                        send_byte((b == 0) ? d0 : (b == 1) ? d1 : c);
                    end
                    idle(gap);
                end
            end
            idle($urandom_range(0, 4));
        end
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
